fb_read_arbiter: RTL and testbench
==================================

Name: fb_read_arbiter

Overview:
- Shares the single read port of the camera frame buffer (dual-port RAM; cam_read drives the write side) between two requesters.
- Video scan-out is hard real-time and always wins. A processing/CPU requester uses a four-phase req/ack handshake and is served only in cycles video leaves idle.
- Sits in the 25 MHz read-clock domain between the frame-buffer read port, the VGA pixel fetcher and the processing logic.

Parameters:
- AW, 15, address width of the frame buffer.
- DW, 8, pixel data width.
- DEPTH, 19200, number of valid pixel locations (160x120); addresses >= DEPTH are illegal.
- RD_LAT, 1, read latency of the RAM in clk cycles (1..3).
- TIMEOUT, 1024, CPU wait cycles in PEND before cpu_timeout fires.

Ports:
- clk  in  1  read-side clock (25 MHz).
- rst  in  1  asynchronous reset, active-low.
- vid_req  in  1  video read request this cycle.
- vid_addr  in  AW  video read address.
- vid_valid  out  1  vid_data valid.
- vid_data  out  DW  pixel returned to video.
- cpu_req  in  1  CPU request, level, four-phase.
- cpu_addr  in  AW  CPU address; sampled when request accepted.
- cpu_ack  out  1  one-cycle acknowledge; cpu_data valid with it.
- cpu_data  out  DW  pixel returned to CPU.
- cpu_err  out  1  qualifies cpu_ack: address out of range, data forced 0.
- cpu_timeout  out  1  one-cycle pulse, CPU starved TIMEOUT cycles.
- mem_addr  out  AW  frame-buffer read address.
- mem_data  in  DW  frame-buffer read data, RD_LAT cycles after mem_addr.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; mem_addr 0.
  - CPU FSM goes to IDLE; tag pipeline cleared; wait counter 0.
  - Any in-flight read is discarded with no ack/valid. Operation resumes on the first clk edge after rst=1.
- Grant, evaluated combinationally each cycle:
  - vid_req=1: grant video; mem_addr=vid_addr.
  - Else if FSM=PEND: grant CPU; mem_addr=latched CPU address.
  - Else: mem_addr holds its previous value; no read tagged.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}, entered on every grant.
  - At its output, mem_data is registered into vid_data or cpu_data. vid_valid or cpu_ack is then asserted for exactly one cycle.
  - Video latency: vid_valid rises RD_LAT+1 edges after the vid_req cycle. Back-to-back vid_req gives back-to-back vid_valid, with order preserved.
  - vid_data and cpu_data hold their last value when not valid.
- CPU FSM:
  - IDLE: on cpu_req=1, latch cpu_addr.
    - Address >= DEPTH: go to ERR.
    - Otherwise: go to PEND.
  - PEND: wait counter increments each cycle. When granted, go to FLIGHT and clear the counter.
  - FLIGHT: on tag arrival, cpu_ack=1, then go to DONE.
  - ERR: next cycle cpu_ack=1, cpu_err=1, cpu_data=0, then go to DONE. No RAM access.
  - DONE: wait for cpu_req=0, then go to IDLE. A new request needs cpu_req low for at least one cycle.
  - Only one CPU transaction is outstanding at a time. Changes on cpu_addr after acceptance are ignored.
- Timeout:
  - When the wait counter reaches TIMEOUT-1 in PEND, cpu_timeout pulses once and the counter saturates.
  - The request is not dropped; it is served at the first video-idle cycle.
- Simultaneous events:
  - vid_req and PEND in the same cycle: video is granted, CPU stays PEND.
  - cpu_req rising in the same cycle as a grant: the CPU is not granted before the next cycle, because acceptance takes one edge.
- Boundary values:
  - Address DEPTH-1 is legal; DEPTH is an error.
  - The wait counter is wide enough for TIMEOUT and does not wrap.

Decomposition:
- Shared package fb_pkg: frame-buffer constants (AW, DW, DEPTH, CAM_SCREEN_X=160, CAM_SCREEN_Y=120), CPU FSM state encoding (IDLE, PEND, FLIGHT, ERR, DONE), owner tag encoding (VID, CPU).
- One sub-module: fb_rd_tag_pipe, the parameterised RD_LAT-deep {valid, owner} shift register with asynchronous active-low clear.

Test Plan:
- Reset mid-flight: CPU grant to addr 100, assert rst=0 before the tag returns -> no cpu_ack. After release, all outputs 0 and FSM IDLE.
- Video only: vid_req=1 for 4 cycles at addrs 0..3, RAM preloaded with 0xA0+addr, RD_LAT=1 -> vid_valid high 4 cycles starting 2 edges later, data A0, A1, A2, A3.
- CPU in idle gap: cpu_req at addr 5000 (RAM 0x5C), vid_req=0 -> mem_addr=5000 the cycle after acceptance; cpu_ack with cpu_data=0x5C, cpu_err=0, RD_LAT+1 edges after grant.
- Contention: CPU PEND while vid_req is held 20 cycles -> CPU not granted during those cycles; granted in the first cycle vid_req=0. Video stream uninterrupted, no vid_valid gaps.
- Starvation: TIMEOUT=16, vid_req held 40 cycles with CPU PEND -> single cpu_timeout pulse on the 16th PEND cycle; ack arrives after video drops.
- Illegal address: cpu_req with addr 19200 -> cpu_ack=1, cpu_err=1, cpu_data=0 two edges after req. No mem_addr change. A second request is ignored until cpu_req has returned low.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Camera frame-buffer constants, CPU read FSM state encoding
//               and read-owner tag encoding shared by the read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int c_CAM_SCREEN_X = 160;
    localparam int c_CAM_SCREEN_Y = 120;
    localparam int c_AW           = 15;
    localparam int c_DW           = 8;
    localparam int c_DEPTH        = c_CAM_SCREEN_X * c_CAM_SCREEN_Y;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PEND   = 3'd1;
    localparam logic [2:0] c_ST_FLIGHT = 3'd2;
    localparam logic [2:0] c_ST_ERR    = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic c_OWN_VID = 1'b0;
    localparam logic c_OWN_CPU = 1'b1;

    function automatic logic fb_addr_legal(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fb_rd_tag_pipe
// Description : RD_LAT-deep {valid, owner} shift register that follows each
//               granted RAM read until its data appears on the read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_owner,
    output logic o_valid,
    output logic o_owner
);

    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] r_owner;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= '0;
                    r_owner <= '0;
                end else begin
                    r_valid <= i_valid;
                    r_owner <= i_owner;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= '0;
                    r_owner <= '0;
                end else begin
                    r_valid <= {r_valid[RD_LAT-2:0], i_valid};
                    r_owner <= {r_owner[RD_LAT-2:0], i_owner};
                end
            end
        end
    endgenerate

    assign o_valid = r_valid[RD_LAT-1];
    assign o_owner = r_owner[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_arbiter
// Description : Shares the frame-buffer read port between hard real-time
//               video scan-out (always wins) and a four-phase CPU requester.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_read_arbiter
    import fb_pkg::*;
#(
    parameter int AW      = c_AW,
    parameter int DW      = c_DW,
    parameter int DEPTH   = c_DEPTH,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_data,
    output logic          cpu_err,
    output logic          cpu_timeout,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data
);

    localparam int              c_WW       = $clog2(TIMEOUT + 1);
    localparam logic [c_WW-1:0] c_WAIT_MAX = c_WW'(TIMEOUT - 1);
    localparam logic [c_WW-1:0] c_WAIT_PRE = c_WW'(TIMEOUT - 2);
    localparam logic [c_WW-1:0] c_WAIT_ONE = c_WW'(1);

    logic [2:0]      r_state;
    logic [AW-1:0]   r_addr;
    logic [c_WW-1:0] r_wait;
    logic [AW-1:0]   r_last_addr;
    logic            r_vid_valid;
    logic [DW-1:0]   r_vid_data;
    logic            r_cpu_ack;
    logic [DW-1:0]   r_cpu_data;
    logic            r_cpu_err;
    logic            r_cpu_timeout;

    logic            w_vid_grant;
    logic            w_cpu_grant;
    logic            w_grant;
    logic [AW-1:0]   w_grant_addr;
    logic            w_tag_valid;
    logic            w_tag_owner;
    logic            w_tag_vid;
    logic            w_tag_cpu;
    logic            w_addr_ok;

    // Grants are masked while reset is low so mem_addr reads 0 during reset.
    assign w_vid_grant  = rst & vid_req;
    assign w_cpu_grant  = rst & ~vid_req & (r_state == c_ST_PEND);
    assign w_grant      = w_vid_grant | w_cpu_grant;
    assign w_grant_addr = w_vid_grant ? vid_addr : r_addr;
    assign mem_addr     = w_grant ? w_grant_addr : r_last_addr;
    assign w_addr_ok    = fb_addr_legal(32'(cpu_addr), 32'(DEPTH));

    fb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_grant),
        .i_owner (w_vid_grant ? c_OWN_VID : c_OWN_CPU),
        .o_valid (w_tag_valid),
        .o_owner (w_tag_owner)
    );

    assign w_tag_vid = w_tag_valid & (w_tag_owner == c_OWN_VID);
    assign w_tag_cpu = w_tag_valid & (w_tag_owner == c_OWN_CPU);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_addr        <= '0;
            r_wait        <= '0;
            r_last_addr   <= '0;
            r_vid_valid   <= 1'b0;
            r_vid_data    <= '0;
            r_cpu_ack     <= 1'b0;
            r_cpu_data    <= '0;
            r_cpu_err     <= 1'b0;
            r_cpu_timeout <= 1'b0;
        end else begin
            r_vid_valid   <= w_tag_vid;
            r_cpu_ack     <= 1'b0;
            r_cpu_err     <= 1'b0;
            r_cpu_timeout <= 1'b0;

            if (w_grant) begin
                r_last_addr <= w_grant_addr;
            end
            if (w_tag_vid) begin
                r_vid_data <= mem_data;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wait  <= '0;
                        r_state <= w_addr_ok ? c_ST_PEND : c_ST_ERR;
                    end
                end
                c_ST_PEND: begin
                    if (w_cpu_grant) begin
                        r_wait  <= '0;
                        r_state <= c_ST_FLIGHT;
                    end else begin
                        // Saturating counter: the pulse fires exactly once per wait.
                        if (r_wait != c_WAIT_MAX) begin
                            r_wait <= r_wait + c_WAIT_ONE;
                        end
                        if (r_wait == c_WAIT_PRE) begin
                            r_cpu_timeout <= 1'b1;
                        end
                    end
                end
                c_ST_FLIGHT: begin
                    if (w_tag_cpu) begin
                        r_cpu_ack  <= 1'b1;
                        r_cpu_data <= mem_data;
                        r_state    <= c_ST_DONE;
                    end
                end
                c_ST_ERR: begin
                    r_cpu_ack  <= 1'b1;
                    r_cpu_err  <= 1'b1;
                    r_cpu_data <= '0;
                    r_state    <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (!cpu_req) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign vid_valid   = r_vid_valid;
    assign vid_data    = r_vid_data;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_data    = r_cpu_data;
    assign cpu_err     = r_cpu_err;
    assign cpu_timeout = r_cpu_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_read_arbiter
// Description : Directed scenarios plus randomized traffic for the frame-buffer
//               read arbiter, checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_read_arbiter;

    localparam int c_AW      = 15;
    localparam int c_DW      = 8;
    localparam int c_DEPTH   = 19200;
    localparam int c_RD_LAT  = 1;
    localparam int c_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              vid_req = 1'b0;
    logic [c_AW-1:0]   vid_addr = '0;
    logic              vid_valid;
    logic [c_DW-1:0]   vid_data;
    logic              cpu_req = 1'b0;
    logic [c_AW-1:0]   cpu_addr = '0;
    logic              cpu_ack;
    logic [c_DW-1:0]   cpu_data;
    logic              cpu_err;
    logic              cpu_timeout;
    logic [c_AW-1:0]   mem_addr;
    logic [c_DW-1:0]   mem_data;

    int n_checks = 0;
    int n_errors = 0;

    fb_read_arbiter #(
        .AW      (c_AW),
        .DW      (c_DW),
        .DEPTH   (c_DEPTH),
        .RD_LAT  (c_RD_LAT),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_data    (cpu_data),
        .cpu_err     (cpu_err),
        .cpu_timeout (cpu_timeout),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
    );

    always #20 clk = ~clk;

    // Frame-buffer RAM: static contents, read data RD_LAT cycles after address.
    logic [7:0]      ram [0:c_DEPTH-1];
    logic [c_AW-1:0] a_pipe [0:c_RD_LAT-1];

    function automatic logic [7:0] ram_rd(input logic [c_AW-1:0] a);
        if (int'(a) < c_DEPTH) return ram[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        for (int i = c_RD_LAT - 1; i > 0; i--) a_pipe[i] <= a_pipe[i-1];
        a_pipe[0] <= mem_addr;
    end
    assign mem_data = ram_rd(a_pipe[c_RD_LAT-1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: reads complete RD_LAT+1 edges after their grant.
    typedef enum {M_IDLE, M_PEND, M_FLIGHT, M_ERR, M_DONE} mstate_t;
    mstate_t         ms = M_IDLE;
    logic [c_AW-1:0] m_addr = '0;
    logic [c_AW-1:0] m_last_addr = '0;
    int              m_pend = 0;
    int              m_edge = 0;
    bit              sch_v   [8];
    bit              sch_cpu [8];
    logic [7:0]      sch_d   [8];
    bit              exp_vv = 0, exp_ca = 0, exp_ce = 0, exp_to = 0;
    logic [7:0]      exp_vd = '0, exp_cd = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms = M_IDLE; m_addr = '0; m_last_addr = '0; m_pend = 0;
            for (int i = 0; i < 8; i++) sch_v[i] = 0;
            exp_vv = 0; exp_ca = 0; exp_ce = 0; exp_to = 0; exp_vd = '0; exp_cd = '0;
        end else begin
            bit arrived;
            int sl;
            m_edge++;
            if (vid_req) begin
                sl = (m_edge + c_RD_LAT) % 8;
                sch_v[sl] = 1; sch_cpu[sl] = 0; sch_d[sl] = ram_rd(vid_addr);
                m_last_addr = vid_addr;
            end else if (ms == M_PEND) begin
                sl = (m_edge + c_RD_LAT) % 8;
                sch_v[sl] = 1; sch_cpu[sl] = 1; sch_d[sl] = ram_rd(m_addr);
                m_last_addr = m_addr;
            end
            exp_vv = 0; exp_ca = 0; exp_ce = 0; exp_to = 0; arrived = 0;
            sl = m_edge % 8;
            if (sch_v[sl]) begin
                if (sch_cpu[sl]) begin exp_ca = 1; exp_cd = sch_d[sl]; arrived = 1; end
                else begin exp_vv = 1; exp_vd = sch_d[sl]; end
                sch_v[sl] = 0;
            end
            case (ms)
                M_IDLE: if (cpu_req) begin
                    m_addr = cpu_addr; m_pend = 0;
                    ms = (int'(cpu_addr) < c_DEPTH) ? M_PEND : M_ERR;
                end
                M_PEND: if (vid_req) begin
                    m_pend++;
                    if (m_pend == c_TIMEOUT - 1) exp_to = 1;
                end else ms = M_FLIGHT;
                M_FLIGHT: if (arrived) ms = M_DONE;
                M_ERR: begin exp_ca = 1; exp_ce = 1; exp_cd = 8'h00; ms = M_DONE; end
                M_DONE: if (!cpu_req) ms = M_IDLE;
                default: ms = M_IDLE;
            endcase
        end
    end

    bit seen_ack = 0;

    task automatic step(input logic vr, input logic [c_AW-1:0] va,
                        input logic cr, input logic [c_AW-1:0] ca);
        logic [c_AW-1:0] exp_ma;
        @(negedge clk);
        check("vid_valid",   32'(vid_valid),   32'(exp_vv));
        check("vid_data",    32'(vid_data),    32'(exp_vd));
        check("cpu_ack",     32'(cpu_ack),     32'(exp_ca));
        check("cpu_err",     32'(cpu_err),     32'(exp_ce));
        check("cpu_data",    32'(cpu_data),    32'(exp_cd));
        check("cpu_timeout", 32'(cpu_timeout), 32'(exp_to));
        seen_ack = cpu_ack;
        vid_req = vr; vid_addr = va; cpu_req = cr; cpu_addr = ca;
        #1;
        if (!rst)               exp_ma = '0;
        else if (vid_req)       exp_ma = vid_addr;
        else if (ms == M_PEND)  exp_ma = m_addr;
        else                    exp_ma = m_last_addr;
        check("mem_addr", 32'(mem_addr), 32'(exp_ma));
    endtask

    function automatic logic [c_AW-1:0] rnd_vaddr();
        return c_AW'($urandom_range(0, c_DEPTH - 1));
    endfunction

    // Holds cpu_req until acknowledged while video runs for vid_cycles cycles.
    task automatic cpu_txn(input logic [c_AW-1:0] addr, input int vid_cycles, input int hold_extra);
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            step(n < vid_cycles, rnd_vaddr(), 1'b1, addr);
            if (seen_ack) done = 1;
        end
        check("txn_acked", 32'(done), 32'd1);
        for (int n = 0; n < hold_extra; n++) step(1'b0, '0, 1'b1, rnd_vaddr());
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit cr;
        logic [c_AW-1:0] ca;
        int vprob;
        for (int i = 0; i < c_DEPTH; i++) ram[i] = 8'((8'hA0 + i) & 8'hFF);
        ram[5000] = 8'h5C;
        for (int i = 0; i < c_RD_LAT; i++) a_pipe[i] = '0;

        repeat (3) step(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (2) step(1'b0, '0, 1'b0, '0);

        for (int i = 0; i < 4; i++) step(1'b1, c_AW'(i), 1'b0, '0);
        repeat (4) step(1'b0, '0, 1'b0, '0);

        cpu_txn(c_AW'(5000), 0, 0);
        cpu_txn(c_AW'(1234), 20, 0);
        cpu_txn(c_AW'(777), 40, 0);
        cpu_txn(c_AW'(c_DEPTH), 0, 4);
        cpu_txn(c_AW'(c_DEPTH - 1), 0, 0);

        // Reset while a CPU read is in flight: no acknowledge may escape.
        step(1'b0, '0, 1'b1, c_AW'(100));
        step(1'b0, '0, 1'b1, c_AW'(100));
        step(1'b0, '0, 1'b1, c_AW'(100));
        rst = 1'b0;
        repeat (3) step(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (2) step(1'b0, '0, 1'b0, '0);
        cpu_txn(c_AW'(100), 3, 0);

        cr = 0; ca = '0; vprob = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) vprob = $urandom_range(0, 100);
            if (cr && seen_ack) cr = 0;
            else if (!cr && ($urandom % 4 == 0)) begin
                cr = 1;
                ca = ($urandom % 6 == 0) ? c_AW'(c_DEPTH + $urandom_range(0, 50)) : rnd_vaddr();
            end else if (cr && ($urandom % 5 == 0)) ca = rnd_vaddr();
            step(($urandom % 100) < vprob, rnd_vaddr(), cr, ca);
        end
        repeat (8) step(1'b0, '0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
